hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter REG_ADDR_W, default 4, register-address width; NUM_REGS = 2**REG_ADDR_W.
REQ-002 The block SHALL have parameter LAT_W, default 2, width of the per-register pending-latency counter; max latency 2**LAT_W-1.
REQ-003 The block SHALL have parameter FLUSH_CYCLES, default 1, range 1..15, number of cycles flush stays asserted per taken branch.
REQ-004 The block SHALL have parameter ZERO_REG_HW, default 1; when 1, register 0 is never marked pending.
REQ-005 The block SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have ports id_rs1 and id_rs2, input, REG_ADDR_W bits each, source registers of the decode-stage instruction.
REQ-008 The block SHALL have ports id_rs1_used and id_rs2_used, input, 1 bit each, qualifying each source.
REQ-009 The block SHALL have port id_valid, input, 1 bit, decode stage holds a real instruction.
REQ-010 The block SHALL have ports ex_issue, input, 1 bit, and ex_rd, input, REG_ADDR_W bits, an instruction entering EX that writes ex_rd.
REQ-011 The block SHALL have port ex_lat, input, LAT_W bits, cycles until the ex_rd result is forwardable; 0 means it is usable next cycle (ALU op).
REQ-012 The block SHALL have port branch_taken, input, 1 bit, branch resolved taken this cycle.
REQ-013 The block SHALL have ports stall and flush, output, 1 bit each.
REQ-014 The block SHALL have port busy, output, 1 bit, indicating any register is pending.
REQ-015 The block SHALL have port stall_cnt, output, 16 bits, performance counter of stall cycles.

Function
REQ-016 Per register r, pending counter cnt[r]: on an edge with ex_issue=1 and no flush, cnt[ex_rd] SHALL load ex_lat; every other nonzero cnt SHALL decrement by 1.
REQ-017 If issue and decrement target the same register in one cycle, the load SHALL win.
REQ-018 With ZERO_REG_HW=1, an issue to ex_rd=0 SHALL leave cnt[0]=0.
REQ-019 A source SHALL be blocked when it is used and either cnt[src]!=0, or ex_issue=1 with ex_rd==src and ex_lat!=0 in the same cycle (load-use).
REQ-020 stall SHALL be combinational and SHALL equal id_valid AND (rs1 blocked OR rs2 blocked) AND NOT flush.
REQ-021 flush SHALL assert combinationally in the cycle branch_taken=1 and SHALL remain high for exactly FLUSH_CYCLES cycles total, via a down-counter.
REQ-022 A branch_taken arriving while flush is active SHALL reload the counter, so the window restarts.
REQ-023 While flush=1, ex_issue SHALL be ignored, so no new pending entry is created; existing entries SHALL keep decrementing.
REQ-024 busy SHALL be the OR of (cnt[r]!=0) over all r.
REQ-025 stall_cnt SHALL increment by 1 on each edge where stall=1, and SHALL saturate at 16'hFFFF.

Reset
REQ-026 While rst=1, at the clock edge all cnt SHALL clear to 0, the flush counter SHALL clear to 0, and stall_cnt SHALL clear to 0.
REQ-027 While rst=1, stall and flush SHALL be forced to 0, and busy SHALL read 0 from the first cycle after reset.
REQ-028 A reset asserted mid-flush or mid-stall SHALL abort the flush or stall immediately, with no residual pending state.

Configuration
REQ-029 Macro HAZ_PERF_EN: when defined, stall_cnt SHALL be implemented per REQ-025; when undefined, stall_cnt SHALL be tied to 0 with no counter flops, and all other behaviour SHALL be unchanged.

Structure
REQ-030 Package haz_pkg SHALL hold the REG_ADDR_W and LAT_W defaults, the stall-counter width constant (16), and the FLUSH_CYCLES default.
REQ-031 Sub-module hazard_sb_entry SHALL implement one cnt register with load/decrement/clear and a pending output, instantiated NUM_REGS times.

Verification
REQ-032 Load-use: issue ex_rd=5 ex_lat=2, id_rs1=5 used -> stall=1 that cycle and the next 2 cycles, then 0; busy falls after 2 cycles.
REQ-033 ALU op: issue ex_rd=3 ex_lat=0, id_rs2=3 used -> stall=0 throughout.
REQ-034 Flush: FLUSH_CYCLES=3, branch_taken pulse -> flush high 3 cycles; a second pulse in cycle 2 -> flush high 2+3 cycles; concurrent ex_issue leaves busy=0.
REQ-035 Zero register: issue ex_rd=0 ex_lat=3, id_rs1=0 used, ZERO_REG_HW=1 -> stall=0, busy=0.
REQ-036 Reset mid-operation: cnt[7]=3 with stall active, assert rst one cycle -> stall=0, busy=0, stall_cnt=0 next cycle.
REQ-037 Saturation (HAZ_PERF_EN): hold a blocking source for 65540 cycles -> stall_cnt=16'hFFFF and stays there; without the macro -> stall_cnt=0.

Source files
------------

// File: rtl/haz_pkg.sv
// Shared defaults and widths for the hazard scoreboard slice.
package haz_pkg;
  localparam int unsigned REG_ADDR_W_DEF   = 4;
  localparam int unsigned LAT_W_DEF        = 2;
  localparam int unsigned STALL_CNT_W      = 16;
  localparam int unsigned FLUSH_CYCLES_DEF = 1;
  // Flush down-counter width covers the full 1..15 FLUSH_CYCLES range.
  localparam int unsigned FLUSH_CNT_W      = 4;
endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: pending-latency counter with load, decrement and clear.
module hazard_sb_entry
  import haz_pkg::*;
#(
  parameter int unsigned LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             pending
);

  logic [LAT_W-1:0] cnt;

  // A load in the same cycle as a decrement takes priority.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign pending = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: load-use stall, branch flush window, busy flag.
// Optional stall performance counter enabled by defining HAZ_PERF_EN.
module hazard_scoreboard
  import haz_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int unsigned LAT_W        = LAT_W_DEF,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter bit          ZERO_REG_HW  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic                   id_valid,
  input  logic                   ex_issue,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic [LAT_W-1:0]       ex_lat,
  input  logic                   branch_taken,
  output logic                   stall,
  output logic                   flush,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [NUM_REGS-1:0]    pending;
  logic                   issue_eff;
  logic                   lat_nz;
  logic                   rs1_blocked;
  logic                   rs2_blocked;

  // Flush is live in the branch cycle itself; the counter covers the rest.
  assign flush = ~rst & (branch_taken | (flush_cnt != '0));

  always_ff @(posedge clk) begin
    if (rst)
      flush_cnt <= '0;
    else if (branch_taken)
      flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    else if (flush_cnt != '0)
      flush_cnt <= flush_cnt - 1'b1;
  end

  assign issue_eff = ex_issue & ~flush & ~rst & ~(ZERO_REG_HW && (ex_rd == '0));
  assign lat_nz    = (ex_lat != '0);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    hazard_sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk      (clk),
      .rst      (rst),
      .load     (issue_eff && (ex_rd == REG_ADDR_W'(r))),
      .load_val (ex_lat),
      .pending  (pending[r])
    );
  end

  always_comb begin
    rs1_blocked = id_rs1_used & (pending[id_rs1] | (issue_eff & lat_nz & (ex_rd == id_rs1)));
    rs2_blocked = id_rs2_used & (pending[id_rs2] | (issue_eff & lat_nz & (ex_rd == id_rs2)));
    stall       = id_valid & (rs1_blocked | rs2_blocked) & ~flush & ~rst;
  end

  assign busy = |pending;

`ifdef HAZ_PERF_EN
  logic [STALL_CNT_W-1:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst)
      perf_q <= '0;
    else if (stall && (perf_q != '1))
      perf_q <= perf_q + 1'b1;
  end

  assign stall_cnt = perf_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
